// File: rtl/compare_stream_tracker.sv
// Streaming sample comparator: compares each accepted sample with the previous one and
// tracks running max/min plus an equal-run count. Define SIGNED_CMP_EN for two's-complement ordering.
module compare_stream_tracker (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       in_valid,
   input  logic [0:3] in_data,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_G,
   output logic       out_L,
   output logic       out_E,
   output logic       out_first,
   output logic [0:3] max_val,
   output logic [0:3] min_val,
   output logic [0:3] eq_run
);

   typedef enum logic {EMPTY, TRACK} state_t;

   state_t     r_state;
   logic [0:3] r_prev;
   logic [0:3] r_max;
   logic [0:3] r_min;
   logic [0:3] r_eq_run;
   logic       r_out_valid;
   logic       r_out_first;
   logic       r_out_g;
   logic       r_out_l;
   logic       r_out_e;

   logic       w_in_xfer;
   logic       w_gt_prev;
   logic       w_lt_prev;

   // Ordering key: flipping the sign bit maps two's complement onto unsigned order.
   function automatic logic [0:3] f_key(input logic [0:3] a);
`ifdef SIGNED_CMP_EN
      return {~a[0], a[1:3]};
`else
      return a;
`endif
   endfunction

   function automatic logic f_gt(input logic [0:3] a, input logic [0:3] b);
      return f_key(a) > f_key(b);
   endfunction

   function automatic logic f_lt(input logic [0:3] a, input logic [0:3] b);
      return f_key(a) < f_key(b);
   endfunction

   function automatic logic [0:3] f_sat_inc(input logic [0:3] a);
      return (a == 4'd15) ? a : a + 4'd1;
   endfunction

   assign in_ready  = !rst && !clr && (!r_out_valid || out_ready);
   assign w_in_xfer = in_valid && in_ready;
   assign w_gt_prev = f_gt(in_data, r_prev);
   assign w_lt_prev = f_lt(in_data, r_prev);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_state     <= EMPTY;
         r_prev      <= '0;
         r_max       <= '0;
         r_min       <= '0;
         r_eq_run    <= '0;
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_g     <= 1'b0;
         r_out_l     <= 1'b0;
         r_out_e     <= 1'b0;
      end else if (w_in_xfer) begin
         r_out_valid <= 1'b1;
         r_prev      <= in_data;
         case (r_state)
            EMPTY: begin
               r_state     <= TRACK;
               r_out_first <= 1'b1;
               r_out_g     <= 1'b0;
               r_out_l     <= 1'b0;
               r_out_e     <= 1'b0;
               r_max       <= in_data;
               r_min       <= in_data;
               r_eq_run    <= '0;
            end
            TRACK: begin
               r_state     <= TRACK;
               r_out_first <= 1'b0;
               r_out_g     <= w_gt_prev;
               r_out_l     <= w_lt_prev;
               r_out_e     <= !w_gt_prev && !w_lt_prev;
               if (f_gt(in_data, r_max))
                  r_max <= in_data;
               if (f_lt(in_data, r_min))
                  r_min <= in_data;
               r_eq_run    <= (w_gt_prev || w_lt_prev) ? 4'd0 : f_sat_inc(r_eq_run);
            end
            default: r_state <= EMPTY;
         endcase
      end else if (out_ready) begin
         // Result consumed with nothing new arriving: drop valid, keep the rest.
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_first = r_out_first;
   assign out_G     = r_out_g;
   assign out_L     = r_out_l;
   assign out_E     = r_out_e;
   assign max_val   = r_max;
   assign min_val   = r_min;
   assign eq_run    = r_eq_run;

endmodule

// File: tb/tb_compare_stream_tracker.sv
// Directed bench for compare_stream_tracker; expectations follow SIGNED_CMP_EN when defined.
module tb_compare_stream_tracker;

   logic       clk = 1'b0;
   logic       rst, clr, in_valid, out_ready;
   logic [0:3] in_data;
   logic       in_ready, out_valid, out_G, out_L, out_E, out_first;
   logic [0:3] max_val, min_val, eq_run;

   int total = 0;
   int bad   = 0;

   compare_stream_tracker dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_G(out_G), .out_L(out_L), .out_E(out_E), .out_first(out_first),
      .max_val(max_val), .min_val(min_val), .eq_run(eq_run)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // flags = {out_valid, out_first, out_G, out_L, out_E}
   task automatic chk_res(input string tag, input logic [4:0] flags,
                          input logic [3:0] mx, input logic [3:0] mn, input logic [3:0] eq);
      chk({tag, ".flags"}, {3'b0, out_valid, out_first, out_G, out_L, out_E}, {3'b0, flags});
      chk({tag, ".max"}, {4'b0, max_val}, {4'b0, mx});
      chk({tag, ".min"}, {4'b0, min_val}, {4'b0, mn});
      chk({tag, ".eq"},  {4'b0, eq_run},  {4'b0, eq});
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = 4'd0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk_res("reset", 5'b00000, 4'd0, 4'd0, 4'd0);
      chk("reset.in_ready", {7'b0, in_ready}, 8'd1);

      // equal run of three 3s
      in_valid = 1'b1; in_data = 4'd3; tick();
      chk_res("eq3.s1", 5'b11000, 4'd3, 4'd3, 4'd0);
      tick();
      chk_res("eq3.s2", 5'b10001, 4'd3, 4'd3, 4'd1);
      tick();
      chk_res("eq3.s3", 5'b10001, 4'd3, 4'd3, 4'd2);
      in_valid = 1'b0; tick();
      chk("eq3.drain", {7'b0, out_valid}, 8'd0);

      // signed versus unsigned ordering: 0111 then 1000
      clr = 1'b1; tick(); clr = 1'b0;
      chk_res("clr1", 5'b00000, 4'd0, 4'd0, 4'd0);
      in_valid = 1'b1; in_data = 4'b0111; tick();
      chk_res("sgn.s1", 5'b11000, 4'd7, 4'd7, 4'd0);
      in_data = 4'b1000; tick();
`ifdef SIGNED_CMP_EN
      chk_res("sgn.s2", 5'b10010, 4'b0111, 4'b1000, 4'd0);
`else
      chk_res("sgn.s2", 5'b10100, 4'b1000, 4'b0111, 4'd0);
`endif
      in_valid = 1'b0; tick();

      // backpressure hold
      clr = 1'b1; tick(); clr = 1'b0;
      in_valid = 1'b1; in_data = 4'd5; tick();
      chk_res("bp.s5", 5'b11000, 4'd5, 4'd5, 4'd0);
      out_ready = 1'b0; in_data = 4'd6; #1;
      chk("bp.in_ready_low", {7'b0, in_ready}, 8'd0);
      tick();
      chk_res("bp.hold1", 5'b11000, 4'd5, 4'd5, 4'd0);
      tick();
      chk_res("bp.hold2", 5'b11000, 4'd5, 4'd5, 4'd0);
      out_ready = 1'b1; #1;
      chk("bp.in_ready_rel", {7'b0, in_ready}, 8'd1);
      tick();
      chk_res("bp.s6", 5'b10100, 4'd6, 4'd5, 4'd0);
      in_valid = 1'b0; tick();
      chk("bp.drain", {7'b0, out_valid}, 8'd0);

      // seventeen equal samples, saturation, then a greater one
      clr = 1'b1; tick(); clr = 1'b0;
      in_valid = 1'b1; in_data = 4'd4;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i == 0)
            chk_res("sat.first", 5'b11000, 4'd4, 4'd4, 4'd0);
         else
            chk_res($sformatf("sat.%0d", i), 5'b10001, 4'd4, 4'd4, (i > 15) ? 4'd15 : 4'(i));
      end
      in_data = 4'd5; tick();
      chk_res("sat.gt", 5'b10100, 4'd5, 4'd4, 4'd0);

      // clr with pending result and a simultaneous input
      in_valid = 1'b0; out_ready = 1'b0; tick();
      chk("clr.pending", {7'b0, out_valid}, 8'd1);
      clr = 1'b1; in_valid = 1'b1; in_data = 4'd9; #1;
      chk("clr.in_ready", {7'b0, in_ready}, 8'd0);
      tick();
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk_res("clr.after", 5'b00000, 4'd0, 4'd0, 4'd0);
      in_valid = 1'b1; in_data = 4'd2; tick();
      chk_res("clr.s2", 5'b11000, 4'd2, 4'd2, 4'd0);

      // rst pulse mid-stream
      in_data = 4'd3; tick();
      chk_res("rst.pre", 5'b10100, 4'd3, 4'd2, 4'd0);
      in_valid = 1'b0; out_ready = 1'b0; tick();
      rst = 1'b1; in_valid = 1'b1; in_data = 4'd9; tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk_res("rst.after", 5'b00000, 4'd0, 4'd0, 4'd0);

      // back-to-back after reset: 10, 2, 2, 11
      in_valid = 1'b1; in_data = 4'd10; tick();
      chk_res("b2b.s10", 5'b11000, 4'd10, 4'd10, 4'd0);
      in_data = 4'd2; tick();
`ifdef SIGNED_CMP_EN
      chk_res("b2b.s2", 5'b10100, 4'd2, 4'd10, 4'd0);
`else
      chk_res("b2b.s2", 5'b10010, 4'd10, 4'd2, 4'd0);
`endif
      tick();
`ifdef SIGNED_CMP_EN
      chk_res("b2b.s2e", 5'b10001, 4'd2, 4'd10, 4'd1);
`else
      chk_res("b2b.s2e", 5'b10001, 4'd10, 4'd2, 4'd1);
`endif
      in_data = 4'd11; tick();
`ifdef SIGNED_CMP_EN
      chk_res("b2b.s11", 5'b10010, 4'd2, 4'd10, 4'd0);
`else
      chk_res("b2b.s11", 5'b10100, 4'd11, 4'd2, 4'd0);
`endif
      in_valid = 1'b0; tick();
      chk("b2b.drain", {7'b0, out_valid}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
